mixed_param_stream_sink: RTL and testbench

// - Receive side of the mixed-parameter data/address stream. Consumes the producer's extended word {data, 32-bit tag}, duplicated address {addr, addr} and rolling status count.
// - Checks the tag, the address-half match and the status sequence, then buffers good words in a FIFO.
// - Presents buffered words downstream on a valid/ready handshake.
// - Sits directly after the producer in the datapath test harness.

---
 rtl/mixed_param_stream_sink.sv | 155 +++++++++++++++
 tb/tb_mixed_param_stream_sink.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixed_param_stream_sink.sv
// Receive side of the mixed-parameter stream: checks tag/address/status and queues good words for a valid/ready consumer.
// Optional status-sequence check under `SINK_SEQ_CHECK_EN; head visible one cycle after push into an empty FIFO.
module mixed_param_stream_sink #(
    parameter int          DATA_WIDTH   = 8,
    parameter int          ADDR_WIDTH   = 16,
    parameter int          STATUS_WIDTH = 4,
    parameter logic [31:0] TAG          = 32'h12345678,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          ERR_LIMIT    = 4,
    localparam int         EXT_W        = DATA_WIDTH + 32,
    localparam int         FADDR_W      = 2 * ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [EXT_W-1:0]        in_ext_data,
    input  logic [FADDR_W-1:0]      in_full_addr,
    input  logic [STATUS_WIDTH-1:0] in_status,
    input  logic                    clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic                    tag_err,
    output logic                    addr_err,
    output logic                    seq_err,
    output logic [7:0]              err_count,
    output logic [7:0]              drop_count,
    output logic                    halted
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

    state_t               state_q, state_d;
    logic [7:0]           err_q, err_d;
    logic [7:0]           drop_q;
    logic                 tag_err_q, tag_err_d;
    logic                 addr_err_q, addr_err_d;
    logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 accept, tag_ok, addr_ok, seq_ok;
    logic [1:0]           n_fail;
    logic [8:0]           err_sum;
    logic                 full, push_req, push, pop, drop;
    logic [ENTRY_W-1:0]   head;

    // A clear pulse discards any word presented in the same cycle.
    assign accept  = in_valid && (state_q != ST_HALT) && !clear;
    assign tag_ok  = (in_ext_data[31:0] == TAG);
    assign addr_ok = (in_full_addr[FADDR_W-1:ADDR_WIDTH] == in_full_addr[ADDR_WIDTH-1:0]);

`ifdef SINK_SEQ_CHECK_EN
    logic [STATUS_WIDTH-1:0] exp_q;
    logic                    seq_err_q;

    // The first word after IDLE only seeds the expectation.
    assign seq_ok = (state_q != ST_RUN) || (in_status == exp_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q     <= '0;
            seq_err_q <= 1'b0;
        end else begin
            if (accept) exp_q <= in_status + STATUS_WIDTH'(1);
            if (clear) seq_err_q <= 1'b0;
            else if (accept && !seq_ok) seq_err_q <= 1'b1;
        end
    end
    assign seq_err = seq_err_q;
`else
    logic unused_status;
    assign unused_status = ^in_status;
    assign seq_ok        = 1'b1;
    assign seq_err       = 1'b0;
`endif

    assign n_fail  = {1'b0, !tag_ok} + {1'b0, !addr_ok} + {1'b0, !seq_ok};
    assign err_sum = {1'b0, err_q} + {7'd0, n_fail};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            err_q      <= '0;
            tag_err_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            tag_err_q  <= tag_err_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        tag_err_d  = tag_err_q;
        addr_err_d = addr_err_q;
        if (clear) begin
            state_d    = ST_IDLE;
            err_d      = '0;
            tag_err_d  = 1'b0;
            addr_err_d = 1'b0;
        end else if (accept) begin
            err_d      = err_sum[8] ? 8'hFF : err_sum[7:0];
            tag_err_d  = tag_err_q | !tag_ok;
            addr_err_d = addr_err_q | !addr_ok;
            state_d    = (32'(err_d) >= ERR_LIMIT) ? ST_HALT : ST_RUN;
        end
    end

    // Fullness is taken before the pop, so a push into a full FIFO drops even while it drains.
    assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign push_req = accept && tag_ok && addr_ok;
    assign push     = push_req && !full;
    assign drop     = push_req && full;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_full_addr[ADDR_WIDTH-1:0], in_ext_data[EXT_W-1:32]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            drop_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign out_valid  = (cnt_q != '0);
    assign out_data   = out_valid ? head[DATA_WIDTH-1:0] : '0;
    assign out_addr   = out_valid ? head[ENTRY_W-1:DATA_WIDTH] : '0;
    assign tag_err    = tag_err_q;
    assign addr_err   = addr_err_q;
    assign err_count  = err_q;
    assign drop_count = drop_q;
    assign halted     = (state_q == ST_HALT);
endmodule

// File: tb/tb_mixed_param_stream_sink.sv
// Bench for mixed_param_stream_sink: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_mixed_param_stream_sink;
    localparam int          DEPTH = 8;
    localparam int          LIMIT = 4;
    localparam logic [31:0] TAGV  = 32'h12345678;
`ifdef SINK_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1, in_valid = 1'b0, clear = 1'b0, out_ready = 1'b0;
    logic [39:0] in_ext_data = '0;
    logic [31:0] in_full_addr = '0;
    logic [3:0]  in_status = '0;
    logic        out_valid, tag_err, addr_err, seq_err, halted;
    logic [7:0]  out_data, err_count, drop_count;
    logic [15:0] out_addr;

    always #5 clk = ~clk;

    mixed_param_stream_sink dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ext_data(in_ext_data),
        .in_full_addr(in_full_addr), .in_status(in_status), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .tag_err(tag_err), .addr_err(addr_err), .seq_err(seq_err),
        .err_count(err_count), .drop_count(drop_count), .halted(halted)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: words as {addr, data} in a queue, counters as plain integers.
    int          m_state;   // 0 idle, 1 run, 2 halt
    logic [3:0]  m_exp;
    logic [23:0] m_q [$];
    bit          m_tag, m_addr, m_seq;
    int          m_err, m_drop;

    task automatic m_step();
        bit full, tok, aok, sok;
        int nerr;
        if (reset) begin
            m_state = 0; m_exp = 0; m_q.delete();
            m_tag = 0; m_addr = 0; m_seq = 0; m_err = 0; m_drop = 0;
            return;
        end
        full = (m_q.size() == DEPTH);
        if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
        if (clear) begin
            m_state = 0; m_tag = 0; m_addr = 0; m_seq = 0; m_err = 0;
        end else if (in_valid && m_state != 2) begin
            tok = (in_ext_data[31:0] == TAGV);
            aok = (in_full_addr[31:16] == in_full_addr[15:0]);
            sok = 1;
            if (SEQ_EN && m_state == 1) sok = (in_status == m_exp);
            m_exp = in_status + 4'd1;
            nerr = (tok ? 0 : 1) + (aok ? 0 : 1) + (sok ? 0 : 1);
            m_err = (m_err + nerr > 255) ? 255 : m_err + nerr;
            m_tag  |= !tok;
            m_addr |= !aok;
            m_seq  |= !sok;
            if (tok && aok) begin
                if (full) m_drop = (m_drop == 255) ? 255 : m_drop + 1;
                else m_q.push_back({in_full_addr[15:0], in_ext_data[39:32]});
            end
            m_state = (m_err >= LIMIT) ? 2 : 1;
        end
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input bit v, input logic [7:0] d, input logic [31:0] tg,
                            input logic [15:0] hi, input logic [15:0] lo, input logic [3:0] st);
        in_valid = v; in_ext_data = {d, tg}; in_full_addr = {hi, lo}; in_status = st;
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 0; clear = 0; out_ready = 0;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({out_valid, tag_err, addr_err, seq_err, halted} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b required 00000", {out_valid, tag_err, addr_err, seq_err, halted});
        end
        n_tests++;
        if ({err_count, drop_count, out_data, out_addr} !== 40'h0) begin
            n_fail++; $display("FAIL reset_counts: got %h required 0", {err_count, drop_count, out_data, out_addr});
        end
    endtask

    task automatic test_basic();
        set_word(1, 8'hA5, TAGV, 16'h0042, 16'h0042, 4'd3);
        tick();
        in_valid = 0;
        n_tests++;
        if ({out_valid, out_data, out_addr} !== {1'b1, 8'hA5, 16'h0042}) begin
            n_fail++; $display("FAIL basic_head: got %h required %h", {out_valid, out_data, out_addr}, {1'b1, 8'hA5, 16'h0042});
        end
        n_tests++;
        if ({err_count, tag_err, addr_err, seq_err} !== 11'h0) begin
            n_fail++; $display("FAIL basic_noerr: got %h required 0", {err_count, tag_err, addr_err, seq_err});
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_pop: got %b required 0", out_valid);
        end
    endtask

    task automatic test_tag_err();
        set_word(1, 8'h11, 32'h12345679, 16'h0042, 16'h0042, 4'd4);
        tick();
        in_valid = 0;
        n_tests++;
        if ({tag_err, err_count, out_valid} !== {1'b1, 8'd1, 1'b0}) begin
            n_fail++; $display("FAIL tag_err: got tag=%b cnt=%0d vld=%b required 1/1/0", tag_err, err_count, out_valid);
        end
    endtask

    task automatic test_seq();
        logic [3:0] sts [4];
        sts[0] = 4'd14; sts[1] = 4'd15; sts[2] = 4'd0; sts[3] = 4'd2;
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            set_word(1, 8'h30 + 8'(i), TAGV, 16'h0100, 16'h0100, sts[i]);
            tick();
            if (i == 2) begin
                n_tests++;
                if (seq_err !== 1'b0) begin
                    n_fail++; $display("FAIL seq_wrap: got %b required 0", seq_err);
                end
            end
        end
        in_valid = 0;
        n_tests++;
        if ({seq_err, err_count} !== {SEQ_EN, 8'(SEQ_EN)}) begin
            n_fail++; $display("FAIL seq_break: got err=%b cnt=%0d required %b/%0d", seq_err, err_count, SEQ_EN, SEQ_EN);
        end
        n_tests++;
        if ({out_valid, out_data} !== {1'b1, 8'h33}) begin
            n_fail++; $display("FAIL seq_push: got %h required 133", {out_valid, out_data});
        end
        tick();
        out_ready = 0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_word(1, 8'(i), TAGV, 16'(i), 16'(i), 4'(i));
            tick();
        end
        n_tests++;
        if ({drop_count, out_data} !== {8'd1, 8'd0}) begin
            n_fail++; $display("FAIL ovf_drop: got drop=%0d head=%0h required 1/0", drop_count, out_data);
        end
        set_word(1, 8'd9, TAGV, 16'd9, 16'd9, 4'd9);
        out_ready = 1;
        tick();
        in_valid = 0;
        n_tests++;
        if ({drop_count, out_data, out_addr} !== {8'd2, 8'd1, 16'd1}) begin
            n_fail++; $display("FAIL ovf_pop_drop: got drop=%0d head=%0h required 2/1", drop_count, out_data);
        end
        for (int i = 0; i < 7; i++) tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_drain: got %b required 0", out_valid);
        end
        out_ready = 0;
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_word(1, 8'hC0 + 8'(i), TAGV, (i < 2) ? 16'h0005 : 16'h0F05, 16'h0005, 4'(i));
            tick();
        end
        n_tests++;
        if ({halted, addr_err, err_count, out_valid} !== {1'b1, 1'b1, 8'd4, 1'b1}) begin
            n_fail++; $display("FAIL halt_enter: got h=%b a=%b cnt=%0d vld=%b required 1/1/4/1", halted, addr_err, err_count, out_valid);
        end
        set_word(1, 8'hEE, TAGV, 16'h0007, 16'h0007, 4'd6);
        out_ready = 1;
        tick();
        tick();
        n_tests++;
        if ({halted, out_valid, err_count} !== {1'b1, 1'b0, 8'd4}) begin
            n_fail++; $display("FAIL halt_ignore: got h=%b vld=%b cnt=%0d required 1/0/4", halted, out_valid, err_count);
        end
        clear = 1;
        tick();
        clear = 0;
        n_tests++;
        if ({halted, err_count, addr_err, out_valid} !== 11'h0) begin
            n_fail++; $display("FAIL clear: got h=%b cnt=%0d a=%b vld=%b required 0", halted, err_count, addr_err, out_valid);
        end
        out_ready = 0;
        set_word(1, 8'h5A, TAGV, 16'h0009, 16'h0009, 4'd9);
        tick();
        in_valid = 0;
        n_tests++;
        if ({out_valid, out_data, seq_err, err_count} !== {1'b1, 8'h5A, 1'b0, 8'd0}) begin
            n_fail++; $display("FAIL clear_idle: got vld=%b d=%h s=%b cnt=%0d required 1/5a/0/0", out_valid, out_data, seq_err, err_count);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_word(1, 8'(i), TAGV, 16'h0001, 16'h0001, 4'(i));
            tick();
        end
        set_word(1, 8'h77, 32'h0, 16'h0001, 16'h0001, 4'd5);
        tick();
        in_valid = 0;
        reset = 1;
        tick();
        reset = 0;
        n_tests++;
        if ({out_valid, err_count, drop_count, halted, tag_err} !== 19'h0) begin
            n_fail++; $display("FAIL reset_mid: got vld=%b cnt=%0d drop=%0d required 0", out_valid, err_count, drop_count);
        end
    endtask

    task automatic test_random();
        logic [3:0] st = 0;
        logic [15:0] a;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            a = 16'($urandom);
            st = ($urandom_range(9) == 0) ? 4'($urandom) : st + 4'd1;
            set_word($urandom_range(9) < 7, 8'($urandom),
                     ($urandom_range(99) < 85) ? TAGV : $urandom,
                     ($urandom_range(99) < 85) ? a : 16'($urandom), a, st);
            clear     = ($urandom_range(99) < 4);
            out_ready = ($urandom_range(1) == 1);
            tick();
            n_tests++;
            if (out_valid !== (m_q.size() != 0) || (out_valid && {out_addr, out_data} !== m_q[0])) begin
                n_fail++; $display("FAIL rnd_head c=%0d: got vld=%b %h required vld=%b", c, out_valid, {out_addr, out_data}, m_q.size() != 0);
            end
            n_tests++;
            if ({err_count, drop_count} !== {m_err[7:0], m_drop[7:0]}) begin
                n_fail++; $display("FAIL rnd_counts c=%0d: got %0d/%0d required %0d/%0d", c, err_count, drop_count, m_err, m_drop);
            end
            n_tests++;
            if ({tag_err, addr_err, seq_err, halted} !== {m_tag, m_addr, m_seq, m_state == 2}) begin
                n_fail++; $display("FAIL rnd_flags c=%0d: got %b required %b", c, {tag_err, addr_err, seq_err, halted}, {m_tag, m_addr, m_seq, m_state == 2});
            end
        end
        in_valid = 0; clear = 0; out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tag_err();
        test_seq();
        test_overflow();
        test_halt();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
